uart_rx_fifo: RTL and testbench

//  Receive half of the UART core that sits behind the NASTI-Lite UART register

---
 rtl/uart_rx_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive half of the UART core. The asynchronous rxd line is synchronised
//   with two flops. Frames are recovered by sampling at mid-bit: start bit,
//   WIDTH data bits LSB first, an optional parity bit, then STOP_BITS stop
//   bits. Good frames go into a small show-ahead FIFO that feeds the
//   data_out valid/ready interface.
//
// Ports
//   clk             clock
//   rstn            asynchronous active-low reset
//   rxd             serial input, asynchronous to clk, idle high
//   data_out        head-of-FIFO word (0 while the FIFO is empty)
//   data_out_valid  FIFO not empty
//   data_out_ready  consumer accepts the head
//   frame_err       1-cycle pulse: a stop bit was sampled low
//   parity_err      1-cycle pulse: parity mismatch
//   overrun         1-cycle pulse: a good frame was dropped because the FIFO was full
//
// Handshake: a word transfers on every cycle where data_out_valid and
//   data_out_ready are both high. data_out is held stable while valid is high
//   and ready is low. Ready is ignored while valid is low.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 27000000,
  parameter int BAUD       = 115200,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CYC = CLOCK_FREQ / BAUD;
  localparam int CW  = $clog2(CYC);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             rxd_s;
  logic             armed;
  logic [CW-1:0]    timer;
  logic             tick;
  logic [IW-1:0]    bit_idx;
  logic             stop_idx;
  logic [WIDTH-1:0] shreg;
  logic             ferr_acc;
  logic             perr_acc;
  logic             par_bad;
  logic             last_stop;
  logic             stop_bad;
  logic             good_frame;

  // Two-flop synchroniser; reset to the idle level so no false start is seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= 2'b11;
    else       sync <= {sync[0], rxd};
  end
  assign rxd_s = sync[1];

  assign tick = (timer == '0);

  // Received parity bit is rxd_s while in S_PARITY; shreg holds the full word.
  assign par_bad = (PARITY == 1) ? ~((^shreg) ^ rxd_s) : ((^shreg) ^ rxd_s);

  // Frame completion: this is the last stop-bit sample cycle.
  assign last_stop  = (state == S_STOP) && tick && (stop_idx == 1'(STOP_BITS - 1));
  assign stop_bad   = ferr_acc | ~rxd_s;
  assign good_frame = last_stop & ~stop_bad & ~perr_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      timer      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
      perr_acc   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (state != S_IDLE) timer <= tick ? CW'(CYC - 1) : timer - CW'(1);
      case (state)
        S_IDLE: begin
          // After reset the line must be seen high once before a start counts.
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_START;
            timer <= CW'(CYC / 2 - 1);
          end
        end
        S_START: begin
          if (tick) begin
            if (!rxd_s) begin
              state    <= S_DATA;
              bit_idx  <= '0;
              ferr_acc <= 1'b0;
              perr_acc <= 1'b0;
            end else begin
              state <= S_IDLE;  // glitch, silently ignored
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {rxd_s, shreg[WIDTH-1:1]};
            if (bit_idx == IW'(WIDTH - 1)) begin
              stop_idx <= 1'b0;
              if (PARITY != 0) state <= S_PARITY;
              else             state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            perr_acc <= par_bad;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (last_stop) begin
              // Leave at mid-bit so a back-to-back start edge is caught in time.
              state      <= S_IDLE;
              frame_err  <= stop_bad;
              parity_err <= perr_acc;
            end else begin
              stop_idx <= 1'b1;
              ferr_acc <= ferr_acc | ~rxd_s;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;

  assign full           = (count == NW'(FIFO_DEPTH));
  assign data_out_valid = (count != '0);
  assign pop            = data_out_valid & data_out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push           = good_frame & (~full | pop);
  assign data_out       = data_out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= good_frame & full & ~pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Two receivers at CYC=16: u_dut is 8N1, u_par is 8E2 (even parity, two
//   stop bits). Frames are bit-banged onto separate lines; a queue model
//   predicts FIFO contents, and pulse counters are compared with the number
//   of error/overrun events the model expects.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       rxd = 1'b1, rxd_p = 1'b1;
  logic       ready = 1'b0, ready_p = 1'b0;
  logic [7:0] dout, dout_p;
  logic       valid, valid_p;
  logic       ferr, perr, ovr, ferr_p, perr_p, ovr_p;

  uart_rx_fifo #(.CLOCK_FREQ(16), .BAUD(1), .WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .data_out(dout), .data_out_valid(valid),
    .data_out_ready(ready), .frame_err(ferr), .parity_err(perr), .overrun(ovr));

  uart_rx_fifo #(.CLOCK_FREQ(16), .BAUD(1), .WIDTH(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_par (
    .clk(clk), .rstn(rstn), .rxd(rxd_p), .data_out(dout_p), .data_out_valid(valid_p),
    .data_out_ready(ready_p), .frame_err(ferr_p), .parity_err(perr_p), .overrun(ovr_p));

  int total = 0;
  int bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- pulse monitor ----------------
  int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, fe_cnt_p = 0, pe_cnt_p = 0, ov_cnt_p = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (ferr)   fe_cnt++;
    if (perr)   pe_cnt++;
    if (ovr)    ov_cnt++;
    if (ferr_p) fe_cnt_p++;
    if (perr_p) pe_cnt_p++;
    if (ovr_p)  ov_cnt_p++;
    if (valid && !prev_valid) rise_cyc = cyc;
    prev_valid = valid;
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_qp[$];
  int fe_exp = 0, pe_exp = 0, ov_exp = 0, fe_exp_p = 0, pe_exp_p = 0, ov_exp_p = 0;
  int start_cyc = 0;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bit period (16 clk). With pop_t set on the final stop bit, ready is
  // raised exactly during the frame-completion cycle (bit start + 11).
  task automatic drive_bit(input bit sel, input logic b, input bit pop_t);
    logic [7:0] head;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        if (sel) rxd_p = b; else rxd = b;
      end
      if (pop_t && i == 10) begin
        chk8("pop_at_t_head", dout, exp_q[0]);
        head = exp_q.pop_front();
        ready = 1'b1;
      end
      if (pop_t && i == 11) ready = 1'b0;
    end
  endtask

  task automatic check_pulses();
    chki("frame_err_count", fe_cnt, fe_exp);
    chki("parity_err_count", pe_cnt, pe_exp);
    chki("overrun_count", ov_cnt, ov_exp);
    chki("frame_err_count_p", fe_cnt_p, fe_exp_p);
    chki("parity_err_count_p", pe_cnt_p, pe_exp_p);
    chki("overrun_count_p", ov_cnt_p, ov_exp_p);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic s0, input logic s1, input bit pop_t);
    bit fbad, pbad, good;
    drive_bit(sel, 1'b0, 1'b0);
    start_cyc = cyc - 15;
    for (int k = 0; k < 8; k++) drive_bit(sel, d[k], 1'b0);
    if (sel) begin
      drive_bit(sel, pbit, 1'b0);
      drive_bit(sel, s0, 1'b0);
      drive_bit(sel, s1, 1'b0);
    end else begin
      drive_bit(sel, s0, pop_t);
    end
    fbad = sel ? (!s0 || !s1) : !s0;
    pbad = sel && ((($countones(d) + int'(pbit)) % 2) != 0);
    good = !fbad && !pbad;
    if (sel) begin
      fe_exp_p += int'(fbad);
      pe_exp_p += int'(pbad);
      if (good) begin
        if (exp_qp.size() < 4) exp_qp.push_back(d); else ov_exp_p++;
      end
    end else begin
      fe_exp += int'(fbad);
      if (good) begin
        if (exp_q.size() < 4) exp_q.push_back(d); else ov_exp++;
      end
    end
    if (fbad) begin
      // Restore idle and let the receiver settle after a low stop bit.
      if (sel) rxd_p = 1'b1; else rxd = 1'b1;
      repeat (40) @(posedge clk);
      #1;
    end
    check_pulses();
  endtask

  task automatic pop_one(input bit sel);
    logic [7:0] head;
    @(posedge clk); #1;
    if (sel) begin
      chk1("valid_p_before_pop", valid_p, 1'b1);
      chk8("data_p_pop", dout_p, exp_qp[0]);
      head = exp_qp.pop_front();
      ready_p = 1'b1;
    end else begin
      chk1("valid_before_pop", valid, 1'b1);
      chk8("data_pop", dout, exp_q[0]);
      head = exp_q.pop_front();
      ready = 1'b1;
    end
    @(posedge clk); #1;
    ready = 1'b0;
    ready_p = 1'b0;
  endtask

  task automatic drain_and_check();
    while (exp_q.size() > 0) pop_one(1'b0);
    while (exp_qp.size() > 0) pop_one(1'b1);
    @(posedge clk); #1;
    chk1("empty_after_drain", valid, 1'b0);
    chk1("empty_after_drain_p", valid_p, 1'b0);
    chk8("data_zero_when_empty", dout, 8'h00);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] d;
    logic       pb;

    // reset state
    repeat (4) @(posedge clk);
    #1;
    chk1("rst_valid", valid, 1'b0);
    chk8("rst_data", dout, 8'h00);
    chk1("rst_frame_err", ferr, 1'b0);
    chk1("rst_parity_err", perr, 1'b0);
    chk1("rst_overrun", ovr, 1'b0);
    chk1("rst_valid_p", valid_p, 1'b0);
    rstn = 1'b1;
    repeat (8) @(posedge clk);

    // 8N1 0xA5 with ready low: valid rises at T+1 (155 clk after start edge) and holds
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    chki("valid_latency", rise_cyc - start_cyc, 155);
    chk1("a5_valid", valid, 1'b1);
    chk8("a5_data", dout, 8'hA5);
    repeat (20) @(posedge clk);
    #1;
    chk1("a5_valid_hold", valid, 1'b1);
    chk8("a5_data_hold", dout, 8'hA5);
    drain_and_check();

    // 3-clk glitch: no push, no pulses, receiver still works afterwards
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk1("glitch_no_push", valid, 1'b0);
    check_pulses();
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    drain_and_check();

    // even parity: 0x01 with p=0 bad, with p=1 good; bad second stop bit
    send_frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    chk1("par_bad_no_push", valid_p, 1'b0);
    send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain_and_check();

    // stop bit low on 0x3C, then a clean 0x55
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("ferr_no_push", valid, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    drain_and_check();

    // overrun on the 5th back-to-back frame
    for (int k = 1; k <= 5; k++) send_frame(1'b0, 8'(k * 8'h11), 1'b0, 1'b1, 1'b1, 1'b0);
    drain_and_check();
    // same, but pop during the 5th frame's completion cycle
    for (int k = 1; k <= 4; k++) send_frame(1'b0, 8'(k * 8'h11), 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    drain_and_check();

    // ready while empty is ignored
    @(posedge clk); #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("empty_ready_valid", valid, 1'b0);
    chk8("empty_ready_data", dout, 8'h00);
    ready = 1'b0;
    send_frame(1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
    drain_and_check();

    // randomized frames on both receivers with random pops
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        send_frame(1'b1, d, pb, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0), 1'b0);
      else
        send_frame(1'b0, d, 1'b0, 1'($urandom_range(0, 7) != 0), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0)  pop_one(1'b0);
      if ($urandom_range(0, 2) == 0 && exp_qp.size() > 0) pop_one(1'b1);
    end
    drain_and_check();

    // reset mid-DATA with two bytes buffered
    send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk1("midrst_valid", valid, 1'b0);
    chk8("midrst_data", dout, 8'h00);
    chk1("midrst_frame_err", ferr, 1'b0);
    chk1("midrst_parity_err", perr, 1'b0);
    chk1("midrst_overrun", ovr, 1'b0);
    exp_q.delete();
    exp_qp.delete();
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
    drain_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
